// File: rtl/vecpack_pkg.sv
// Shared definitions for the reduction-NAND cosim vector packer.
// Field order on the input stream is a9..a1 then b9..b1 (idx 0..17),
// widths 9..1 then 9..1, packed MSB-first into PACK_W bits.
// Helpers give each field's width, mask, LSB position in the packed
// word, and the reduction NAND of a field taken from a packed word.
package vecpack_pkg;

    localparam int PACK_W  = 90;
    localparam int NFIELDS = 18;

    typedef logic [4:0] idx_t;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    localparam idx_t LAST_IDX = 5'd17;

    function automatic logic [3:0] field_w(input idx_t i);
        if (i < 5'd9) return 4'(5'd9 - i);
        else          return 4'(5'd18 - i);
    endfunction

    function automatic logic [8:0] field_mask(input idx_t i);
        return 9'((10'd1 << field_w(i)) - 10'd1);
    endfunction

    // Fields arrive MSB-first, so a field's LSB sits above every field
    // that follows it in the stream.
    function automatic logic [6:0] field_lsb(input idx_t i);
        logic [6:0] s;
        s = '0;
        for (int j = 0; j < NFIELDS; j++) begin
            if (j > int'(i)) s = s + 7'(field_w(idx_t'(j)));
        end
        return s;
    endfunction

    function automatic logic field_nand(input logic [PACK_W-1:0] p, input idx_t i);
        logic [8:0] sl;
        sl = 9'(p >> field_lsb(i));
        return (sl & field_mask(i)) != field_mask(i);
    endfunction

endpackage

// File: rtl/vecpack_nand_model.sv
// Combinational reference model of the device under test: turns a packed
// 90-bit operand word into the expected 128-bit response word.
// Ports:
//   packed_vec  in   PACK_W  packed operands (a9 at the top, b1 at bit 0)
//   expected    out  OUT_W   expected response
// Each result is a 1-bit reduction NAND zero-extended into its slot.
// oa_k lands in the slot b_k occupies on the input side, ob_k in the
// slot of a_k; the six 6-bit oc results sit at [125:90].
module vecpack_nand_model
    import vecpack_pkg::*;
#(
    parameter int OUT_W = 128
) (
    input  logic [PACK_W-1:0] packed_vec,
    output logic [OUT_W-1:0]  expected
);

    always_comb begin
        expected = '0;
        for (int k = 1; k <= 9; k++) begin
            // a_k is idx 9-k, b_k is idx 18-k
            expected[field_lsb(idx_t'(18 - k))] = field_nand(packed_vec, idx_t'(9 - k));
            expected[field_lsb(idx_t'(9 - k))]  = field_nand(packed_vec, idx_t'(18 - k));
        end
        expected[90]  = field_nand(packed_vec, 5'd0);   // oc1 = ~&a9
        expected[96]  = field_nand(packed_vec, 5'd0);   // oc2 = ~&a9
        expected[102] = field_nand(packed_vec, 5'd6);   // oc3 = ~&a3
        expected[108] = field_nand(packed_vec, 5'd15);  // oc4 = ~&b3
        expected[114] = field_nand(packed_vec, 5'd8);   // oc5 = ~&a1
        expected[120] = field_nand(packed_vec, 5'd17);  // oc6 = ~&b1
    end

endmodule

// File: rtl/vecpack_tx.sv
// Transmit-side packer for the 128-bit reduction-NAND cosim vector bus.
// Collects 18 operand fields (a9..a1, b9..b1) from a valid/ready stream,
// packs them MSB-first into the low 90 bits and presents the word on a
// second valid/ready stream. One vector every 19 cycles at best.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   fld_valid/ready/data/last   field input stream (data right-justified)
//   vec_valid/ready/data        packed vector output stream
//   err, clr_err          sticky protocol error flag and its clear
//   exp_data              expected DUT response (SV_VECPACK_EXPECT_EN only)
// Build option: define SV_VECPACK_EXPECT_EN to add exp_data and its model.
//
// state   | meaning
// COLLECT | accepting fields into acc, idx counts beats
// HOLD    | full vector presented, waiting for vec_ready
module vecpack_tx
    import vecpack_pkg::*;
#(
    parameter int   OUT_W    = 128,
    parameter logic FILL_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fld_valid,
    output logic             fld_ready,
    input  logic [8:0]       fld_data,
    input  logic             fld_last,
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic [OUT_W-1:0] vec_data,
    output logic             err,
    input  logic             clr_err
`ifdef SV_VECPACK_EXPECT_EN
   ,output logic [OUT_W-1:0] exp_data
`endif
);

    state_e            state;
    idx_t              idx;
    logic [PACK_W-1:0] acc;
    logic [PACK_W-1:0] acc_nxt;
    logic [8:0]        fmask;
    logic              fire;
    logic              ovf;
    logic              last_bad;
    logic              err_set;

    assign fmask    = field_mask(idx);
    assign fire     = fld_valid && fld_ready && (state == COLLECT);
    assign ovf      = |(fld_data & ~fmask);
    assign last_bad = fld_last != (idx == LAST_IDX);
    assign err_set  = fire && (ovf || last_bad);
    assign acc_nxt  = (acc << field_w(idx)) | PACK_W'(fld_data & fmask);

    // acc only changes while collecting, so it doubles as the held vector.
    assign vec_data = {{(OUT_W-PACK_W){FILL_BIT}}, acc};

`ifdef SV_VECPACK_EXPECT_EN
    logic [OUT_W-1:0] exp_nxt;

    vecpack_nand_model #(.OUT_W(OUT_W)) u_model (
        .packed_vec (acc_nxt),
        .expected   (exp_nxt)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            idx       <= '0;
            acc       <= '0;
            err       <= 1'b0;
            vec_valid <= 1'b0;
            fld_ready <= 1'b0;
`ifdef SV_VECPACK_EXPECT_EN
            exp_data  <= '0;
`endif
        end else begin
            // a new error in the same cycle beats the clear
            err <= err_set || (err && !clr_err);
            case (state)
                COLLECT: begin
                    fld_ready <= 1'b1;
                    vec_valid <= 1'b0;
                    if (fire) begin
                        if (fld_last && idx != LAST_IDX) begin
                            idx <= '0;
                            acc <= '0;
                        end else if (idx == LAST_IDX) begin
                            acc       <= acc_nxt;
                            state     <= HOLD;
                            vec_valid <= 1'b1;
                            fld_ready <= 1'b0;
`ifdef SV_VECPACK_EXPECT_EN
                            exp_data  <= exp_nxt;
`endif
                        end else begin
                            acc <= acc_nxt;
                            idx <= idx + 5'd1;
                        end
                    end
                end
                HOLD: begin
                    if (vec_ready) begin
                        state     <= COLLECT;
                        idx       <= '0;
                        acc       <= '0;
                        vec_valid <= 1'b0;
                        fld_ready <= 1'b1;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_vecpack_tx.sv
module tb_vecpack_tx;

    logic         clk;
    logic         rst_n;
    logic         fld_valid;
    logic         fld_ready;
    logic [8:0]   fld_data;
    logic         fld_last;
    logic         vec_valid;
    logic         vec_ready;
    logic [127:0] vec_data;
    logic         err;
    logic         clr_err;
`ifdef SV_VECPACK_EXPECT_EN
    logic [127:0] exp_data;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] flds[18];
    logic [8:0] pat[18] = '{9'h15A, 9'h0C3, 9'h02D, 9'h01B, 9'h00E, 9'h009, 9'h005, 9'h002, 9'h001,
                            9'h0A5, 9'h03C, 9'h052, 9'h024, 9'h011, 9'h006, 9'h002, 9'h001, 9'h000};

    vecpack_tx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fld_valid (fld_valid),
        .fld_ready (fld_ready),
        .fld_data  (fld_data),
        .fld_last  (fld_last),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .vec_data  (vec_data),
        .err       (err),
        .clr_err   (clr_err)
`ifdef SV_VECPACK_EXPECT_EN
       ,.exp_data  (exp_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic int wid(input int i);
        return (i < 9) ? 9 - i : 18 - i;
    endfunction

    function automatic logic [127:0] pack_ref();
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 18; i++)
            v = (v << wid(i)) | (128'(flds[i]) & ((128'd1 << wid(i)) - 128'd1));
        return v;
    endfunction

    // Called at a negedge; returns at the negedge after the beat is taken.
    task automatic send_beat(input logic [8:0] d, input logic l);
        logic rdy;
        int   n;
        fld_valid = 1'b1;
        fld_data  = d;
        fld_last  = l;
        n = 0;
        do begin
            rdy = fld_ready;
            @(negedge clk);
            n++;
        end while (!rdy && n < 60);
        chk("beat_timeout", {127'b0, rdy}, 128'd1);
        fld_valid = 1'b0;
        fld_last  = 1'b0;
    endtask

    task automatic send_range(input int first, input int last_i, input int last_at);
        for (int i = first; i <= last_i; i++) send_beat(flds[i], i == last_at);
    endtask

    task automatic fill_ones();
        for (int i = 0; i < 18; i++) flds[i] = 9'(((1 << wid(i)) - 1));
    endtask

    task automatic fill_pat();
        for (int i = 0; i < 18; i++) flds[i] = pat[i];
    endtask

    task automatic step_out();
        @(negedge clk);
        chk("vec_valid_drop", {127'b0, vec_valid}, 128'd0);
    endtask

    initial begin
        logic [127:0] want;
        rst_n = 1'b0; fld_valid = 1'b0; fld_data = '0; fld_last = 1'b0;
        vec_ready = 1'b1; clr_err = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_vec_valid", {127'b0, vec_valid}, 128'd0);
        chk("rst_fld_ready", {127'b0, fld_ready}, 128'd0);
        chk("rst_vec_data", vec_data, 128'd0);
        chk("rst_err", {127'b0, err}, 128'd0);
`ifdef SV_VECPACK_EXPECT_EN
        chk("rst_exp", exp_data, 128'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {127'b0, fld_ready}, 128'd1);

        // 1: all-ones fields
        fill_ones();
        send_range(0, 17, 17);
        chk("t1_valid", {127'b0, vec_valid}, 128'd1);
        chk("t1_data", vec_data, {38'b0, {90{1'b1}}});
        chk("t1_err", {127'b0, err}, 128'd0);
        chk("t1_fld_ready", {127'b0, fld_ready}, 128'd0);
`ifdef SV_VECPACK_EXPECT_EN
        chk("t1_exp", exp_data, 128'd0);
`endif
        step_out();
        chk("t1_ready_again", {127'b0, fld_ready}, 128'd1);

        // 2: a9 = 1FE
        fill_ones();
        flds[0] = 9'h1FE;
        send_range(0, 17, 17);
        chk("t2_a9", {119'b0, vec_data[89:81]}, 128'h1FE);
        chk("t2_low", {47'b0, vec_data[80:0]}, {47'b0, {81{1'b1}}});
        chk("t2_top", {90'b0, vec_data[127:90]}, 128'd0);
`ifdef SV_VECPACK_EXPECT_EN
        chk("t2_exp", exp_data, (128'd1 << 36) | (128'd1 << 90) | (128'd1 << 96));
`endif
        step_out();

        // 3: back-pressure, stray beats must not be consumed
        fill_pat();
        want = pack_ref();
        vec_ready = 1'b0;
        send_range(0, 17, 17);
        fld_valid = 1'b1; fld_data = 9'h1FF; fld_last = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("t3_valid", {127'b0, vec_valid}, 128'd1);
            chk("t3_data", vec_data, want);
            chk("t3_fld_ready", {127'b0, fld_ready}, 128'd0);
            @(negedge clk);
        end
        fld_valid = 1'b0;
        vec_ready = 1'b1;
        step_out();
        chk("t3_err", {127'b0, err}, 128'd0);
        send_range(0, 17, 17);
        chk("t3_next", vec_data, want);
        step_out();

        // 4: early last on idx 4, then a clean vector, then clear
        fill_pat();
        send_range(0, 4, 4);
        chk("t4_err", {127'b0, err}, 128'd1);
        chk("t4_no_valid", {127'b0, vec_valid}, 128'd0);
        @(negedge clk);
        chk("t4_still_no_valid", {127'b0, vec_valid}, 128'd0);
        send_range(0, 17, 17);
        chk("t4_valid", {127'b0, vec_valid}, 128'd1);
        chk("t4_data", vec_data, pack_ref());
        chk("t4_err_sticky", {127'b0, err}, 128'd1);
        step_out();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("t4_err_clr", {127'b0, err}, 128'd0);

        // 5: overflow on a1 (idx 8) with a2 = 2'b10
        fill_pat();
        flds[8] = 9'h003;
        send_range(0, 17, 17);
        chk("t5_err", {127'b0, err}, 128'd1);
        chk("t5_a1", {127'b0, vec_data[45]}, 128'd1);
        chk("t5_a2", {126'b0, vec_data[47:46]}, 128'd2);
        chk("t5_data", vec_data, pack_ref());
        step_out();

        // 6: reset after 10 fields
        fill_pat();
        send_range(0, 9, 17);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid", {127'b0, vec_valid}, 128'd0);
        chk("t6_fld_ready", {127'b0, fld_ready}, 128'd0);
        chk("t6_data", vec_data, 128'd0);
        chk("t6_err", {127'b0, err}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        flds[0] = 9'h0F0;
        send_range(0, 17, 17);
        chk("t6_vec_valid", {127'b0, vec_valid}, 128'd1);
        chk("t6_vec", vec_data, pack_ref());
        chk("t6_err_after", {127'b0, err}, 128'd0);
        step_out();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
